ctrl_sequencer: RTL and testbench

Registered, parametrised control-unit stage that sits between instruction decode and the execute/vector datapath. It decodes a 5-bit opcode (plus 3-bit ALU sub-op) into the 19-bit control word, presents it one cycle later with a valid/stall handshake, and sequences vector memory ops over `VEC_BEATS` output beats. After each jump/branch it holds off fetch for `BRANCH_BUBBLES` cycles, and it supports flush from execute.

---
 rtl/ctrl_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Registered control-unit stage between instruction decode and the
//            execute/vector datapath. Decodes a 5-bit opcode (plus 3-bit ALU
//            sub-op for R-type) into a 19-bit control word and presents it
//            one cycle after acceptance with a valid/stall handshake. Vector
//            memory ops (VLDH, VSTB) are replayed over VEC_BEATS output beats,
//            jumps/branches hold off fetch for BRANCH_BUBBLES cycles, and a
//            flush from execute kills the held and incoming instruction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   opcode/aluop valid
//   in_ready   out  instruction accepted when in_valid & in_ready
//   opcode     in   [4:0] instruction opcode
//   aluop      in   [2:0] ALU sub-op for R-type (opcode 00000)
//   flush      in   synchronous kill of held and incoming instruction
//   stall_in   in   downstream cannot take the current output
//   out_valid  out  control word valid this cycle
//   ctrl       out  [18:0] {jmp_sel[1:0], write_register, mem_write,
//                   reg_write, vcsub, alu_op[2:0], sel_op_b[1:0], sel_rs2,
//                   branch_sel[1:0], sel_op_a[1:0], sel_write_data,
//                   write_register_vec, sel_rs1}
//   beat_idx   out  [BEAT_W-1:0] current vector beat, 0 for scalar ops
//   last_beat  out  final beat of a vector op, 1 for every scalar output
//   illegal    out  current output comes from an undefined opcode
// ============================================================================
module ctrl_sequencer #(
  parameter int VEC_BEATS      = 4,
  parameter int BRANCH_BUBBLES = 1,
  parameter int BEAT_W         = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [2:0]        aluop,
  input  logic              flush,
  input  logic              stall_in,
  output logic              out_valid,
  output logic [18:0]       ctrl,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              last_beat,
  output logic              illegal
);

  // Bubble counter must hold the value BRANCH_BUBBLES itself.
  localparam int CNT_W = (BRANCH_BUBBLES > 0) ? $clog2(BRANCH_BUBBLES + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT_IDX = BEAT_W'(VEC_BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE      = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  BUBBLE_LOAD   = CNT_W'(BRANCH_BUBBLES);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);

  // Opcode map
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_MOV   = 5'b01101;
  localparam logic [4:0] OP_01001 = 5'b01001;
  localparam logic [4:0] OP_01010 = 5'b01010;
  localparam logic [4:0] OP_01011 = 5'b01011;
  localparam logic [4:0] OP_00101 = 5'b00101;
  localparam logic [4:0] OP_00010 = 5'b00010;
  localparam logic [4:0] OP_00100 = 5'b00100;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_BLT   = 5'b01100;
  localparam logic [4:0] OP_VLDH  = 5'b11011;
  localparam logic [4:0] OP_VSTB  = 5'b11101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEC    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic                out_valid_q, out_valid_d;
  logic [18:0]         ctrl_q,      ctrl_d;
  logic [BEAT_W-1:0]   beat_idx_q,  beat_idx_d;
  logic                last_beat_q, last_beat_d;
  logic                illegal_q,   illegal_d;
  logic [CNT_W-1:0]    bub_cnt_q,   bub_cnt_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [18:0] dec_ctrl;
  logic        dec_illegal;
  logic        dec_vec;
  logic        dec_branch;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_vec     = 1'b0;
    case (opcode)
      OP_RTYPE: dec_ctrl = {6'b001010, aluop, 10'b0000000000};
      OP_ADDI:  dec_ctrl = 19'b0010100000100000000;
      OP_MOV:   dec_ctrl = 19'b0010100000100000001;
      OP_01001: dec_ctrl = 19'b0010100010100000000;
      OP_01010: dec_ctrl = 19'b0010100100100000000;
      OP_01011: dec_ctrl = 19'b0010100110100000000;
      OP_00101: dec_ctrl = 19'b0010100000000000001;
      OP_00010: dec_ctrl = 19'b0010000001000000000;
      OP_00100: dec_ctrl = 19'b0001000000000010000;
      OP_JMP:   dec_ctrl = 19'b0100000000000000000;
      OP_BLT:   dec_ctrl = 19'b0000000010011000001;
      OP_VLDH: begin
        dec_ctrl = 19'b0000000001000000110;
        dec_vec  = 1'b1;
      end
      OP_VSTB: begin
        dec_ctrl = 19'b0001000000000011000;
        dec_vec  = 1'b1;
      end
      default:  dec_illegal = 1'b1;
    endcase
  end

  // jmp_sel lives in [18:17], branch_sel in [6:5].
  assign dec_branch = (dec_ctrl[18:17] != 2'b00) || (dec_ctrl[6:5] != 2'b00);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic out_stalled;
  logic accept;

  assign out_stalled = out_valid_q & stall_in;
  assign in_ready    = (state_q == ST_IDLE) & ~out_stalled & ~flush;
  assign accept      = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    beat_idx_d  = beat_idx_q;
    last_beat_d = last_beat_q;
    illegal_d   = illegal_q;
    bub_cnt_d   = bub_cnt_q;

    if (flush) begin
      // Flush beats stall: the held word is discarded regardless of downstream.
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      beat_idx_d  = '0;
      bub_cnt_d   = '0;
    end else if (!out_stalled) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            illegal_d   = dec_illegal;
            beat_idx_d  = '0;
            if (dec_vec && (VEC_BEATS > 1)) begin
              state_d     = ST_VEC;
              last_beat_d = 1'b0;
            end else begin
              last_beat_d = 1'b1;
              if (dec_branch && (BRANCH_BUBBLES > 0)) begin
                state_d   = ST_BUBBLE;
                bub_cnt_d = BUBBLE_LOAD;
              end
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end

        ST_VEC: begin
          if (last_beat_q) begin
            // Final beat transfers this cycle; nothing can be accepted in VEC.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            beat_idx_d  = '0;
          end else begin
            beat_idx_d  = beat_idx_q + BEAT_ONE;
            last_beat_d = ((beat_idx_q + BEAT_ONE) == LAST_BEAT_IDX);
          end
        end

        ST_BUBBLE: begin
          // The first BUBBLE cycle still shows the branch word; once it
          // transfers the output goes empty while the counter runs down.
          out_valid_d = 1'b0;
          if (bub_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            bub_cnt_d = bub_cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          beat_idx_d  = '0;
          bub_cnt_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      beat_idx_q  <= '0;
      last_beat_q <= 1'b0;
      illegal_q   <= 1'b0;
      bub_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      beat_idx_q  <= beat_idx_d;
      last_beat_q <= last_beat_d;
      illegal_q   <= illegal_d;
      bub_cnt_q   <= bub_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ctrl      = ctrl_q;
  assign beat_idx  = beat_idx_q;
  assign last_beat = last_beat_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Purpose  : Directed self-checking bench for ctrl_sequencer
//            (VEC_BEATS=4, BRANCH_BUBBLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  localparam int VB = 4;
  localparam int BB = 2;
  localparam int BW = 2;

  localparam logic [18:0] C_ADD  = 19'b0010100010000000000;
  localparam logic [18:0] C_ADDI = 19'b0010100000100000000;
  localparam logic [18:0] C_MOV  = 19'b0010100000100000001;
  localparam logic [18:0] C_JMP  = 19'b0100000000000000000;
  localparam logic [18:0] C_BLT  = 19'b0000000010011000001;
  localparam logic [18:0] C_VLDH = 19'b0000000001000000110;
  localparam logic [18:0] C_VSTB = 19'b0001000000000011000;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    opcode;
  logic [2:0]    aluop;
  logic          flush;
  logic          stall_in;
  logic          out_valid;
  logic [18:0]   ctrl;
  logic [BW-1:0] beat_idx;
  logic          last_beat;
  logic          illegal;

  int checks;
  int errors;

  int exp_beat [7] = '{0, 1, 2, 2, 2, 2, 3};
  int stall_seq[7] = '{0, 0, 1, 1, 1, 0, 0};

  ctrl_sequencer #(
    .VEC_BEATS      (VB),
    .BRANCH_BUBBLES (BB)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .aluop     (aluop),
    .flush     (flush),
    .stall_in  (stall_in),
    .out_valid (out_valid),
    .ctrl      (ctrl),
    .beat_idx  (beat_idx),
    .last_beat (last_beat),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 2ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    opcode   = 5'd0;
    aluop    = 3'd0;
    flush    = 1'b0;
    stall_in = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl",      32'(ctrl),      32'd0);
    chk("rst_beat",      32'(beat_idx),  32'd0);
    chk("rst_last",      32'(last_beat), 32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    #1 rst = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- back-to-back ADD, ADDI, MOV ----------------
    in_valid = 1'b1; opcode = 5'b00000; aluop = 3'b001;
    tick();
    opcode = 5'b01000; aluop = 3'b000;
    #1;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_ctrl",  32'(ctrl),      32'(C_ADD));
    chk("add_last",  32'(last_beat), 32'd1);
    chk("add_ready", 32'(in_ready),  32'd1);
    tick();
    opcode = 5'b01101;
    #1;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_ctrl",  32'(ctrl),      32'(C_ADDI));
    tick();
    in_valid = 1'b0;
    #1;
    chk("mov_valid", 32'(out_valid), 32'd1);
    chk("mov_ctrl",  32'(ctrl),      32'(C_MOV));
    chk("mov_beat",  32'(beat_idx),  32'd0);
    tick();
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // ---------------- VLDH with stall on beat 2 ----------------
    in_valid = 1'b1; opcode = 5'b11011;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      stall_in = stall_seq[i][0];
      #1;
      chk($sformatf("vldh_beat%0d", i),  32'(beat_idx),  32'(exp_beat[i]));
      chk($sformatf("vldh_last%0d", i),  32'(last_beat), (exp_beat[i] == VB - 1) ? 32'd1 : 32'd0);
      chk($sformatf("vldh_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("vldh_ready%0d", i), 32'(in_ready),  32'd0);
      chk($sformatf("vldh_ctrl%0d", i),  32'(ctrl),      32'(C_VLDH));
      tick();
    end
    stall_in = 1'b0;
    #1;
    chk("vldh_end_valid", 32'(out_valid), 32'd0);
    chk("vldh_end_ready", 32'(in_ready),  32'd1);

    // ---------------- JMP with 2 bubbles, in_valid held ----------------
    in_valid = 1'b1; opcode = 5'b10000;
    tick();
    opcode = 5'b01000;
    #1;
    chk("jmp_valid", 32'(out_valid), 32'd1);
    chk("jmp_ctrl",  32'(ctrl),      32'(C_JMP));
    chk("jmp_ready", 32'(in_ready),  32'd0);
    for (int i = 0; i < BB; i++) begin
      tick();
      #1;
      chk($sformatf("bub%0d_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("bub%0d_ready", i), 32'(in_ready),  32'd0);
    end
    tick();
    #1;
    chk("postjmp_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("postjmp_valid", 32'(out_valid), 32'd1);
    chk("postjmp_ctrl",  32'(ctrl),      32'(C_ADDI));
    tick();

    // ---------------- flush on beat 1 of VSTB ----------------
    in_valid = 1'b1; opcode = 5'b11101;
    tick();
    #1;
    chk("vstb_beat0", 32'(beat_idx), 32'd0);
    chk("vstb_ctrl",  32'(ctrl),     32'(C_VSTB));
    tick();
    flush = 1'b1; opcode = 5'b01000;
    #1;
    chk("vstb_beat1",   32'(beat_idx), 32'd1);
    chk("flush_ready",  32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_beat",  32'(beat_idx),  32'd0);
    chk("flush_ready_after", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("postflush_valid", 32'(out_valid), 32'd1);
    chk("postflush_ctrl",  32'(ctrl),      32'(C_ADDI));
    tick();

    // ---------------- illegal opcode, then held under stall ----------------
    in_valid = 1'b1; opcode = 5'b11111;
    tick();
    opcode = 5'b01000; stall_in = 1'b1;
    #1;
    chk("ill_valid",   32'(out_valid), 32'd1);
    chk("ill_ctrl",    32'(ctrl),      32'd0);
    chk("ill_illegal", 32'(illegal),   32'd1);
    chk("ill_last",    32'(last_beat), 32'd1);
    chk("stall_ready", 32'(in_ready),  32'd0);
    tick();
    #1;
    chk("hold_valid",   32'(out_valid), 32'd1);
    chk("hold_illegal", 32'(illegal),   32'd1);
    chk("hold_ctrl",    32'(ctrl),      32'd0);
    stall_in = 1'b0; in_valid = 1'b0;
    tick();
    #1;
    chk("ill_drain", 32'(out_valid), 32'd0);

    // ---------------- BLT, async reset mid-bubble ----------------
    in_valid = 1'b1; opcode = 5'b01100;
    tick();
    in_valid = 1'b0;
    #1;
    chk("blt_ctrl",  32'(ctrl),     32'(C_BLT));
    chk("blt_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid",   32'(out_valid), 32'd0);
    chk("arst_ctrl",    32'(ctrl),      32'd0);
    chk("arst_beat",    32'(beat_idx),  32'd0);
    chk("arst_last",    32'(last_beat), 32'd0);
    chk("arst_illegal", 32'(illegal),   32'd0);
    #1 rst = 1'b1;
    tick();
    #1;
    chk("arst_ready_after", 32'(in_ready),  32'd1);
    chk("arst_valid_after", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
